// File: rtl/sa_ax_arbiter_pkg.sv
// sa_ax_arbiter_pkg: shared field widths and order-entry sizing for the AX arbiter
package sa_ax_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int TRANS_MST_ID_W = 5;
  localparam int TRANS_BURST_W = 2;
  localparam int TRANS_DATA_LEN_W = 3;
  localparam int TRANS_DATA_SIZE_W = 3;
  localparam int MST_AMT_DFLT = 2;
  localparam int OUTSTANDING_AMT_DFLT = 8;
  function automatic int ord_w(int mst_amt);
    return $clog2(mst_amt) + TRANS_DATA_LEN_W;
  endfunction
endpackage

// File: rtl/sa_ax_arbiter_if.sv
// sa_ax_arbiter_if: master-side request bus, slave-side AX bus and data-channel order outputs
interface sa_ax_arbiter_if
  import sa_ax_arbiter_pkg::*;
#(
  parameter int MST_AMT = MST_AMT_DFLT,
  parameter int OUTSTANDING_AMT = OUTSTANDING_AMT_DFLT
) ();
  localparam int MST_ID_W = $clog2(MST_AMT);
  localparam int OUTST_CTN_W = $clog2(OUTSTANDING_AMT) + 1;
  logic [MST_AMT*TRANS_MST_ID_W-1:0] dsp_AxID_i;
  logic [MST_AMT*ADDR_WIDTH-1:0] dsp_AxADDR_i;
  logic [MST_AMT*TRANS_BURST_W-1:0] dsp_AxBURST_i;
  logic [MST_AMT*TRANS_DATA_LEN_W-1:0] dsp_AxLEN_i;
  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0] dsp_AxSIZE_i;
  logic [MST_AMT-1:0] dsp_AxVALID_i;
  logic [MST_AMT-1:0] dsp_AxREADY_o;
  logic [MST_ID_W+TRANS_MST_ID_W-1:0] s_AxID_o;
  logic [ADDR_WIDTH-1:0] s_AxADDR_o;
  logic [TRANS_BURST_W-1:0] s_AxBURST_o;
  logic [TRANS_DATA_LEN_W-1:0] s_AxLEN_o;
  logic [TRANS_DATA_SIZE_W-1:0] s_AxSIZE_o;
  logic s_AxVALID_o;
  logic s_AxREADY_i;
  logic s_xVALID_i;
  logic s_xREADY_i;
  logic [MST_ID_W-1:0] sa_xDATA_mst_id_o;
  logic sa_xDATA_disable_o;
  logic [OUTST_CTN_W-1:0] sa_Ax_outst_ctn_o;
  modport master (
    input dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i, dsp_AxVALID_i,
    input s_AxREADY_i, s_xVALID_i, s_xREADY_i,
    output dsp_AxREADY_o, s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o, s_AxVALID_o,
    output sa_xDATA_mst_id_o, sa_xDATA_disable_o, sa_Ax_outst_ctn_o
  );
  modport slave (
    output dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i, dsp_AxSIZE_i, dsp_AxVALID_i,
    output s_AxREADY_i, s_xVALID_i, s_xREADY_i,
    input dsp_AxREADY_o, s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o, s_AxVALID_o,
    input sa_xDATA_mst_id_o, sa_xDATA_disable_o, sa_Ax_outst_ctn_o
  );
endinterface

// File: rtl/sa_ax_arbiter_fifo.sv
// sa_ax_arbiter_fifo: order FIFO remembering {master, AxLEN} of accepted AX requests
module sa_ax_arbiter_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full,
  output logic [AW:0] count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign count = wptr - rptr;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign dout = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/sa_ax_arbiter.sv
// sa_ax_arbiter: round-robin AX arbiter with order FIFO; SA_AX_FIXED_PRIORITY_EN selects fixed priority
module sa_ax_arbiter
  import sa_ax_arbiter_pkg::*;
#(
  parameter int MST_AMT = MST_AMT_DFLT,
  parameter int OUTSTANDING_AMT = OUTSTANDING_AMT_DFLT
) (
  input logic ACLK_i,
  input logic ARESETn_i,
  sa_ax_arbiter_if.master bus
);
  localparam int MST_ID_W = $clog2(MST_AMT);
  localparam int OUTST_CTN_W = $clog2(OUTSTANDING_AMT) + 1;
  localparam int ORD_W = ord_w(MST_AMT);
  logic reg_valid, fifo_full, fifo_empty, ax_hs, x_hs, capture, found, pop;
  logic [MST_ID_W-1:0] win, idx, reg_mst, head_mst;
  logic [TRANS_MST_ID_W-1:0] reg_id;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [TRANS_BURST_W-1:0] reg_burst;
  logic [TRANS_DATA_LEN_W-1:0] reg_len, head_len, beat;
  logic [TRANS_DATA_SIZE_W-1:0] reg_size;
`ifndef SA_AX_FIXED_PRIORITY_EN
  logic [MST_ID_W-1:0] rr_ptr;
`endif
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < MST_AMT; i++) begin
`ifdef SA_AX_FIXED_PRIORITY_EN
      idx = MST_ID_W'(i);
`else
      idx = MST_ID_W'((int'(rr_ptr) + i) % MST_AMT);
`endif
      if (!found && bus.dsp_AxVALID_i[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // the register refills in the same cycle it hands off, so grants run back-to-back
  assign bus.s_AxVALID_o = reg_valid & ~fifo_full;
  assign ax_hs = bus.s_AxVALID_o & bus.s_AxREADY_i;
  assign capture = found & (~reg_valid | ax_hs);
  assign bus.dsp_AxREADY_o = (capture && ARESETn_i) ? MST_AMT'(1) << win : '0;
  always_ff @(posedge ACLK_i or negedge ARESETn_i)
    if (!ARESETn_i) begin
      reg_valid <= 1'b0;
      reg_mst <= '0;
      reg_id <= '0;
      reg_addr <= '0;
      reg_burst <= '0;
      reg_len <= '0;
      reg_size <= '0;
    end else if (capture) begin
      reg_valid <= 1'b1;
      reg_mst <= win;
      reg_id <= bus.dsp_AxID_i[win*TRANS_MST_ID_W +: TRANS_MST_ID_W];
      reg_addr <= bus.dsp_AxADDR_i[win*ADDR_WIDTH +: ADDR_WIDTH];
      reg_burst <= bus.dsp_AxBURST_i[win*TRANS_BURST_W +: TRANS_BURST_W];
      reg_len <= bus.dsp_AxLEN_i[win*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
      reg_size <= bus.dsp_AxSIZE_i[win*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    end else if (ax_hs) reg_valid <= 1'b0;
`ifndef SA_AX_FIXED_PRIORITY_EN
  always_ff @(posedge ACLK_i or negedge ARESETn_i)
    if (!ARESETn_i) rr_ptr <= '0;
    else if (capture) rr_ptr <= (win == MST_ID_W'(MST_AMT-1)) ? '0 : win + 1'b1;
`endif
  assign bus.s_AxID_o = {reg_mst, reg_id};
  assign bus.s_AxADDR_o = reg_addr;
  assign bus.s_AxBURST_o = reg_burst;
  assign bus.s_AxLEN_o = reg_len;
  assign bus.s_AxSIZE_o = reg_size;
  // beats arriving with nothing outstanding belong to no burst and are dropped
  assign x_hs = bus.s_xVALID_i & bus.s_xREADY_i & ~fifo_empty;
  assign pop = x_hs & (beat == head_len);
  always_ff @(posedge ACLK_i or negedge ARESETn_i)
    if (!ARESETn_i) beat <= '0;
    else if (pop) beat <= '0;
    else if (x_hs) beat <= beat + 1'b1;
  sa_ax_arbiter_fifo #(.DEPTH(OUTSTANDING_AMT), .WIDTH(ORD_W)) u_fifo (
    .clk(ACLK_i),
    .rst_n(ARESETn_i),
    .push(ax_hs),
    .pop(pop),
    .din({reg_mst, reg_len}),
    .dout({head_mst, head_len}),
    .empty(fifo_empty),
    .full(fifo_full),
    .count(bus.sa_Ax_outst_ctn_o)
  );
  assign bus.sa_xDATA_mst_id_o = head_mst;
  assign bus.sa_xDATA_disable_o = fifo_empty;
endmodule

// File: tb/tb_sa_ax_arbiter.sv
// tb_sa_ax_arbiter: directed scenarios checked against a queue-based transaction model
module tb_sa_ax_arbiter;
  import sa_ax_arbiter_pkg::*;
  localparam int M = 2;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sa_ax_arbiter_if #(.MST_AMT(M), .OUTSTANDING_AMT(D)) bus ();
  sa_ax_arbiter #(.MST_AMT(M), .OUTSTANDING_AMT(D)) dut (.ACLK_i(clk), .ARESETn_i(rst_n), .bus(bus));
  typedef struct {int mst; int id; longint addr; int burst; int len; int size;} txn_t;
  txn_t pend;
  bit pend_v;
  txn_t ord [$];
  int beats, rr;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic peek();
    @(negedge clk);
    #1;
  endtask
  task automatic drive(int m, bit v, int id, longint addr, int len);
    bus.dsp_AxVALID_i[m] = v;
    bus.dsp_AxID_i[m*TRANS_MST_ID_W +: TRANS_MST_ID_W] = TRANS_MST_ID_W'(id);
    bus.dsp_AxADDR_i[m*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(addr);
    bus.dsp_AxBURST_i[m*TRANS_BURST_W +: TRANS_BURST_W] = TRANS_BURST_W'(1 + m);
    bus.dsp_AxLEN_i[m*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W] = TRANS_DATA_LEN_W'(len);
    bus.dsp_AxSIZE_i[m*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W] = TRANS_DATA_SIZE_W'(2 + m);
  endtask
  task automatic drain(int n);
    cyc();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    bus.s_AxREADY_i = 1'b1;
    bus.s_xVALID_i = 1'b1;
    bus.s_xREADY_i = 1'b1;
    repeat (n) cyc();
    bus.s_xVALID_i = 1'b0;
  endtask
  initial forever begin
    bit found, cap, hs, sv, dhs;
    int w, j;
    @(negedge clk);
    if (!rst_n) begin
      pend_v = 0;
      ord.delete();
      beats = 0;
      rr = 0;
      chk("rst_s_valid", 64'(bus.s_AxVALID_o), 0);
      chk("rst_ready", 64'(bus.dsp_AxREADY_o), 0);
      chk("rst_ctn", 64'(bus.sa_Ax_outst_ctn_o), 0);
      chk("rst_disable", 64'(bus.sa_xDATA_disable_o), 1);
    end else begin
      sv = pend_v && ord.size() < D;
      hs = sv && bus.s_AxREADY_i;
      found = 0;
      w = 0;
      for (int k = 0; k < M; k++) begin
        j = (rr + k) % M;
        if (!found && bus.dsp_AxVALID_i[j]) begin
          found = 1;
          w = j;
        end
      end
      cap = found && (!pend_v || hs);
      chk("s_valid", 64'(bus.s_AxVALID_o), 64'(sv));
      chk("ready", 64'(bus.dsp_AxREADY_o), cap ? (64'd1 << w) : 64'd0);
      chk("ctn", 64'(bus.sa_Ax_outst_ctn_o), 64'(ord.size()));
      chk("disable", 64'(bus.sa_xDATA_disable_o), 64'(ord.size() == 0));
      if (sv) begin
        chk("s_id", 64'(bus.s_AxID_o), 64'(pend.mst * 32 + pend.id));
        chk("s_addr", 64'(bus.s_AxADDR_o), 64'(pend.addr));
        chk("s_burst", 64'(bus.s_AxBURST_o), 64'(pend.burst));
        chk("s_len", 64'(bus.s_AxLEN_o), 64'(pend.len));
        chk("s_size", 64'(bus.s_AxSIZE_o), 64'(pend.size));
      end
      if (ord.size() > 0) chk("head_mst", 64'(bus.sa_xDATA_mst_id_o), 64'(ord[0].mst));
      dhs = ord.size() > 0 && bus.s_xVALID_i && bus.s_xREADY_i;
      if (dhs) begin
        if (beats == ord[0].len) begin
          ord.delete(0);
          beats = 0;
        end else beats++;
      end
      if (hs) ord.push_back(pend);
      if (cap) begin
        pend.mst = w;
        pend.id = int'(bus.dsp_AxID_i[w*TRANS_MST_ID_W +: TRANS_MST_ID_W]);
        pend.addr = longint'(bus.dsp_AxADDR_i[w*ADDR_WIDTH +: ADDR_WIDTH]);
        pend.burst = int'(bus.dsp_AxBURST_i[w*TRANS_BURST_W +: TRANS_BURST_W]);
        pend.len = int'(bus.dsp_AxLEN_i[w*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W]);
        pend.size = int'(bus.dsp_AxSIZE_i[w*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W]);
        pend_v = 1;
`ifdef SA_AX_FIXED_PRIORITY_EN
        rr = 0;
`else
        rr = (w + 1) % M;
`endif
      end else if (hs) pend_v = 0;
    end
  end
  initial begin
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    bus.s_AxREADY_i = 1'b0;
    bus.s_xVALID_i = 1'b0;
    bus.s_xREADY_i = 1'b0;
    repeat (2) cyc();
    peek();
    chk("reset_ctn", 64'(bus.sa_Ax_outst_ctn_o), 0);
    chk("reset_disable", 64'(bus.sa_xDATA_disable_o), 1);
    chk("reset_s_valid", 64'(bus.s_AxVALID_o), 0);
    cyc();
    rst_n = 1'b1;
    drive(0, 1, 3, 'h1000, 0);
    drive(1, 1, 7, 'h2000, 0);
    bus.s_AxREADY_i = 1'b1;
    bus.s_xVALID_i = 1'b1;
    bus.s_xREADY_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      peek();
      chk("rr_grant", 64'(bus.dsp_AxREADY_o), (i % 2) ? 64'd2 : 64'd1);
      if (i > 0) chk("rr_id_msb", 64'(bus.s_AxID_o[5]), 64'((i - 1) % 2));
      cyc();
    end
    drain(8);
    bus.s_AxREADY_i = 1'b0;
    drive(0, 1, 2, 'hA0, 0);
    peek();
    chk("hold_grant", 64'(bus.dsp_AxREADY_o), 1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      peek();
      chk("hold_valid", 64'(bus.s_AxVALID_o), 1);
      chk("hold_addr", 64'(bus.s_AxADDR_o), 'hA0);
      chk("hold_no_ready", 64'(bus.dsp_AxREADY_o), 0);
      cyc();
    end
    drain(4);
    drive(1, 1, 9, 'h3000, 0);
    bus.s_AxREADY_i = 1'b1;
    repeat (12) cyc();
    peek();
    chk("full_ctn", 64'(bus.sa_Ax_outst_ctn_o), 8);
    chk("full_stall", 64'(bus.s_AxVALID_o), 0);
    cyc();
    bus.s_xVALID_i = 1'b1;
    bus.s_xREADY_i = 1'b1;
    drive(1, 0, 9, 'h3000, 0);
    peek();
    chk("full_pop_stall", 64'(bus.s_AxVALID_o), 0);
    cyc();
    bus.s_xVALID_i = 1'b0;
    peek();
    chk("after_pop_ctn", 64'(bus.sa_Ax_outst_ctn_o), 7);
    chk("after_pop_resume", 64'(bus.s_AxVALID_o), 1);
    cyc();
    peek();
    chk("refill_ctn", 64'(bus.sa_Ax_outst_ctn_o), 8);
    drain(12);
    drive(1, 1, 4, 'h4000, 3);
    bus.s_AxREADY_i = 1'b1;
    peek();
    chk("m1_grant", 64'(bus.dsp_AxREADY_o), 2);
    cyc();
    drive(1, 0, 4, 'h4000, 3);
    peek();
    chk("m1_hs", 64'(bus.s_AxVALID_o), 1);
    cyc();
    peek();
    chk("m1_ctn", 64'(bus.sa_Ax_outst_ctn_o), 1);
    chk("m1_head", 64'(bus.sa_xDATA_mst_id_o), 1);
    cyc();
    bus.s_xVALID_i = 1'b1;
    bus.s_xREADY_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      peek();
      chk("burst_open", 64'(bus.sa_xDATA_disable_o), 0);
      cyc();
    end
    bus.s_xVALID_i = 1'b0;
    peek();
    chk("burst_closed", 64'(bus.sa_xDATA_disable_o), 1);
    chk("burst_ctn", 64'(bus.sa_Ax_outst_ctn_o), 0);
    drain(2);
    drive(0, 1, 5, 'h5000, 0);
    repeat (5) cyc();
    bus.s_xVALID_i = 1'b1;
    bus.s_xREADY_i = 1'b1;
    peek();
    chk("pushpop_ctn", 64'(bus.sa_Ax_outst_ctn_o), 4);
    chk("pushpop_hs", 64'(bus.s_AxVALID_o), 1);
    cyc();
    peek();
    chk("pushpop_hold", 64'(bus.sa_Ax_outst_ctn_o), 4);
    drain(10);
    drive(1, 1, 6, 'h6000, 7);
    repeat (3) cyc();
    drive(1, 0, 6, 'h6000, 7);
    bus.s_xVALID_i = 1'b1;
    bus.s_xREADY_i = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b0;
    bus.s_xVALID_i = 1'b0;
    drive(0, 1, 1, 'h7000, 0);
    drive(1, 1, 2, 'h8000, 0);
    peek();
    chk("mid_rst_valid", 64'(bus.s_AxVALID_o), 0);
    chk("mid_rst_ready", 64'(bus.dsp_AxREADY_o), 0);
    chk("mid_rst_ctn", 64'(bus.sa_Ax_outst_ctn_o), 0);
    chk("mid_rst_disable", 64'(bus.sa_xDATA_disable_o), 1);
    repeat (2) cyc();
    rst_n = 1'b1;
    peek();
    chk("post_rst_grant", 64'(bus.dsp_AxREADY_o), 1);
    cyc();
    peek();
    chk("post_rst_next", 64'(bus.dsp_AxREADY_o), 2);
    chk("post_rst_id_msb", 64'(bus.s_AxID_o[5]), 0);
    drain(10);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_ax_arbiter.md
SA_AX_ARBITER -- requirements
Module: sa_ax_arbiter

Interface
REQ-001 Parameters SHALL be: MST_AMT 2, number of masters; OUTSTANDING_AMT 8, order-FIFO depth; OUTST_CTN_W clog2(OUTSTANDING_AMT)+1; ADDR_WIDTH 32; TRANS_MST_ID_W 5; TRANS_BURST_W 2; TRANS_DATA_LEN_W 3; TRANS_DATA_SIZE_W 3; MST_ID_W clog2(MST_AMT).
REQ-002 The clock port SHALL be ACLK_i, input, 1 bit; there SHALL be one clock.
REQ-003 The reset port SHALL be ARESETn_i, input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-004 Master-side inputs SHALL be dsp_AxID_i, dsp_AxADDR_i, dsp_AxBURST_i, dsp_AxLEN_i and dsp_AxSIZE_i, each packed field-width*MST_AMT, plus dsp_AxVALID_i, input, MST_AMT bits.
REQ-005 dsp_AxREADY_o SHALL be an output of MST_AMT bits carrying per-master ready.
REQ-006 Slave-side outputs SHALL be s_AxID_o (MST_ID_W+TRANS_MST_ID_W bits, {master index, AxID}), s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o and s_AxVALID_o; s_AxREADY_i SHALL be an input of 1 bit.
REQ-007 s_xVALID_i and s_xREADY_i SHALL be inputs of 1 bit each, carrying the slave write-data handshake.
REQ-008 Outputs to the data-channel arbiter SHALL be sa_xDATA_mst_id_o (MST_ID_W bits, head master), sa_xDATA_disable_o (1 bit, order FIFO empty) and sa_Ax_outst_ctn_o (OUTST_CTN_W bits).

Function
REQ-009 Arbitration SHALL be round-robin: search starts at rr_ptr, lowest index wins wrap-around, over dsp_AxVALID_i.
REQ-010 A one-entry output register SHALL hold the granted request; it SHALL capture when empty, or when s_AxVALID_o & s_AxREADY_i in the same cycle (back-to-back, no bubble).
REQ-011 dsp_AxREADY_o[winner] SHALL be 1 only in the capture cycle; all other bits SHALL be 0; latency from master handshake to s_AxVALID_o SHALL be 1 cycle.
REQ-012 On capture, rr_ptr SHALL become winner+1, wrapping to 0 after MST_AMT-1.
REQ-013 s_AxVALID_o SHALL be reg_valid & ~fifo_full; once asserted it SHALL remain asserted, with stable payload, until s_AxREADY_i.
REQ-014 The order FIFO SHALL push {reg master index, reg AxLEN} on a slave Ax handshake.
REQ-015 A beat counter SHALL increment on s_xVALID_i & s_xREADY_i; at count == head AxLEN it SHALL pop the FIFO and clear to 0.
REQ-016 A simultaneous push and pop SHALL leave sa_Ax_outst_ctn_o unchanged.
REQ-017 With the FIFO full, no Ax handshake SHALL occur; a pop in that cycle SHALL permit a handshake the next cycle.
REQ-018 A data handshake while the FIFO is empty SHALL be ignored; the counter SHALL hold.
REQ-019 The AxLEN count SHALL be modular at TRANS_DATA_LEN_W bits; AxLEN = 0 SHALL pop on the first beat.

Reset
REQ-020 While ARESETn_i is low, the following SHALL be 0: reg_valid, s_AxVALID_o, dsp_AxREADY_o, rr_ptr, the beat counter, the FIFO pointers and sa_Ax_outst_ctn_o; sa_xDATA_disable_o SHALL be 1.
REQ-021 Reset assertion mid-burst SHALL discard all outstanding entries and the register without a handshake; the first grant after release SHALL go to master 0 if it is requesting.

Configuration
REQ-022 With SA_AX_FIXED_PRIORITY_EN defined, arbitration SHALL be fixed priority (lowest index wins) and rr_ptr SHALL be removed; without it, arbitration SHALL be round-robin per REQ-009/012.

Structure
REQ-023 A shared package SHALL hold the field-width localparams and the {mst_id, len} order-entry width.
REQ-024 The order FIFO SHALL be the existing fifo sub-module instance; the arbiter SHALL be inline logic.

Verification
REQ-025 Masters 0 and 1 both request continuously with s_AxREADY_i=1 -> grants alternate 0,1,0,1 and s_AxID_o MSB alternates.
REQ-026 s_AxREADY_i held 0 for 5 cycles with a grant pending -> s_AxVALID_o stays 1 with stable ADDR, and no further dsp_AxREADY_o pulses.
REQ-027 Eight AxLEN=0 handshakes with no data beats -> sa_Ax_outst_ctn_o=8 and s_AxVALID_o drops; one data beat -> count 7, then the handshake resumes.
REQ-028 Master 1 request with AxLEN=3 -> sa_xDATA_mst_id_o=1 and the pop occurs on the 4th data beat; disable_o returns to 1.
REQ-029 Push and pop in the same cycle at count 4 -> the count stays 4.
REQ-030 ARESETn_i pulsed low mid-burst, then master 0 and master 1 request -> all outputs at reset values and the first grant goes to master 0.
